trng_crc_collector: RTL
=======================

Name: trng_crc_collector

Overview:
Parametrised entropy collector that sits between the raw entropy source(s) and the AES post-processor/serial path.
- XOR-folds NSRC sampled words per valid cycle and compresses SAMPLES_PER_OUT folds into one OUT_WIDTH word with a CRC (Galois LFSR) engine.
- Runs a repetition-count health test on each produced word.
- Buffers produced words in a small FIFO behind a valid/read handshake.

Parameters:
- NSRC, 2, number of parallel entropy sources.
- SRC_WIDTH, 32, bits per source sample.
- OUT_WIDTH, 8, output word width and CRC degree (2..16).
- POLY, 8'h07, CRC polynomial without the x^OUT_WIDTH term; the default is x^8+x^2+x+1.
- SAMPLES_PER_OUT, 1, valid samples folded into each output word (1..15).
- RCT_CUTOFF, 16, identical consecutive words that trip the health test (2..255).
- FIFO_DEPTH, 4, output FIFO depth; must be a power of two.

Ports:
- i_clk, input, 1, clock.
- i_reset, input, 1, synchronous, active-high reset.
- i_sampled, input, NSRC*SRC_WIDTH, raw source samples; source k occupies [k*SRC_WIDTH +: SRC_WIDTH].
- i_sampled_valid, input, 1, i_sampled is valid this cycle.
- i_read, input, 1, consumer pops the head word; effective only while o_valid=1.
- i_clear_fail, input, 1, clears a health failure and restarts collection.
- o_dat, output, OUT_WIDTH, FIFO head word; all zeros when empty.
- o_valid, output, 1, FIFO non-empty and no health failure.
- o_level, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
- o_health_fail, output, 1, sticky health-test failure.
- o_drop_cnt, output, 8, saturating count of words dropped because the FIFO was full.

Behaviour:
- Reset: every output, the CRC state, the sample counter, the RCT counter and the FIFO are zero. The last-word register is invalid.
- Fold: fold = XOR of all NSRC source words.
- CRC step: processes fold MSB first, one bit per iteration, for SRC_WIDTH iterations, all combinational.
  - fb = state[MSB] ^ bit; state = (state<<1) ^ (fb ? POLY : 0).
- Word start: the CRC state is 0 at the start of every output word, so words are independent.
- On each cycle with i_sampled_valid=1 and o_health_fail=0:
  - the sample counter increments;
  - when it reaches SAMPLES_PER_OUT, the step result is the completed word and the counter and CRC state return to 0;
  - otherwise the CRC state register takes the step result.
- Latency: a word completed at edge N is in the FIFO after edge N; o_valid=1 from cycle N+1.
- RCT on each completed word W:
  - W equals the last word: increment the repeat count; otherwise the count becomes 1. The first word after reset/clear sets the count to 1.
  - Count reaching RCT_CUTOFF: o_health_fail is set, W is discarded, the FIFO is flushed (o_level=0, o_valid=0) and sample acceptance stops.
- FIFO:
  - A completed word that passes the RCT while the FIFO is full is dropped and o_drop_cnt increments, saturating at 255.
  - A pop at edge N frees space before a push at the same edge N, so a full FIFO with simultaneous read and push keeps its level and drops nothing.
  - Simultaneous push and pop at non-full level: the level is unchanged.
  - A pop while empty is ignored; a pop while o_health_fail=1 is ignored.
- i_clear_fail (1 cycle): clears o_health_fail, the RCT state, the CRC state and the sample counter. o_drop_cnt is preserved. Collection resumes the next cycle. If i_clear_fail is high while no failure is present, only the CRC/RCT/counter restart applies.
- i_reset mid-word: the partial word is discarded.

Optional Feature:
- Macro: TRNG_APT_EN.
- Defined: adds an adaptive proportion test with localparams APT_WINDOW=64 and APT_CUTOFF=13.
  - The first word of each window is the reference.
  - Each later word in the window equal to the reference increments a match count.
  - Reaching APT_CUTOFF sets o_health_fail with the same flush and stop behaviour as the RCT.
  - The window restarts after 64 words or on i_clear_fail.
- Undefined: no APT logic; only the RCT drives o_health_fail.

Decomposition:
- Shared package trng_pkg: the default POLY constant, the CRC-step function (width-generic via parameters), and the APT window/cutoff constants.
- Sub-module trng_word_fifo: synchronous FIFO with push, pop, flush, level and full.

Test Plan:
1. NSRC=2, i_sampled = {32'h00000002, 32'h00000003} with valid for 1 cycle -> o_valid=1 the next cycle, o_dat=8'h07.
2. Single valid sample, fold = 32'h00000100 -> o_dat=8'h15. With SAMPLES_PER_OUT=2 and fold 32'h00000001 twice -> one word only, appearing after the second sample.
3. Constant input producing identical words, RCT_CUTOFF=16:
   - o_health_fail rises on the 16th word, o_level=0, o_valid=0, further samples are ignored;
   - an i_clear_fail pulse -> o_health_fail=0 and the next word is accepted.
4. FIFO_DEPTH=4, no reads, 6 distinct words -> o_level=4, o_drop_cnt=2. Then read and push in the same cycle -> level stays 4, o_drop_cnt stays 2.
5. i_reset asserted after 1 of 2 samples (SAMPLES_PER_OUT=2) -> every output returns to 0, and the next word uses only post-reset samples.
6. With TRNG_APT_EN defined: 13 matching words within a 64-word window, interleaved with distinct words so the RCT never trips -> o_health_fail=1. With the macro undefined, the same stimulus -> o_health_fail=0.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared constants and the width-generic CRC step for the entropy collector.
// The step handles CRCs up to 16 bits over data words up to 64 bits wide.
package trng_pkg;

  localparam logic [7:0] POLY_DEFAULT = 8'h07;
  localparam int APT_WINDOW = 64;
  localparam int APT_CUTOFF = 13;
  localparam int CRC_MAXW = 16;
  localparam int DATA_MAXW = 64;

  // Galois LFSR, MSB-first, one bit per iteration over the low dw bits.
  function automatic logic [CRC_MAXW-1:0] crc_step(
    input logic [CRC_MAXW-1:0] state,
    input logic [CRC_MAXW-1:0] poly,
    input int ow,
    input logic [DATA_MAXW-1:0] data,
    input int dw
  );
    logic [CRC_MAXW-1:0] st;
    logic [CRC_MAXW-1:0] mask;
    logic fb;
    mask = CRC_MAXW'((17'd1 << ow) - 17'd1);
    st = state & mask;
    for (int i = DATA_MAXW - 1; i >= 0; i--) begin
      if (i < dw) begin
        fb = st[4'(ow - 1)] ^ data[6'(i)];
        st = ((st << 1) ^ (fb ? poly : '0)) & mask;
      end
    end
    return st;
  endfunction

endpackage

// File: rtl/trng_word_fifo.sv
// Output word FIFO; a pop frees space for a push at the same edge.
// DEPTH must be a power of two and at least 2.
module trng_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic do_pop;
  logic do_push;

  assign full = (level == LW'(DEPTH));
  assign do_pop = pop && (level != '0);
  assign do_push = push && (!full || do_pop);
  assign dout = (level != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/trng_crc_collector.sv
// XOR-fold + CRC entropy collector with repetition-count health test.
// Define TRNG_APT_EN to add the adaptive proportion test.
module trng_crc_collector
  import trng_pkg::*;
#(
  parameter int NSRC = 2,
  parameter int SRC_WIDTH = 32,
  parameter int OUT_WIDTH = 8,
  parameter logic [OUT_WIDTH-1:0] POLY = OUT_WIDTH'(POLY_DEFAULT),
  parameter int SAMPLES_PER_OUT = 1,
  parameter int RCT_CUTOFF = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [NSRC*SRC_WIDTH-1:0]   i_sampled,
  input  logic                        i_sampled_valid,
  input  logic                        i_read,
  input  logic                        i_clear_fail,
  output logic [OUT_WIDTH-1:0]        o_dat,
  output logic                        o_valid,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_health_fail,
  output logic [7:0]                  o_drop_cnt
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [SRC_WIDTH-1:0] fold;
  logic [OUT_WIDTH-1:0] crc_q;
  logic [OUT_WIDTH-1:0] step;
  logic [OUT_WIDTH-1:0] last_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_nxt;
  logic [7:0] rct_q;
  logic [7:0] rct_nxt;
  logic [7:0] drop_q;
  logic [LW-1:0] level;
  logic last_vld;
  logic fail_q;
  logic accept;
  logic done;
  logic rct_trip;
  logic apt_trip;
  logic trip;
  logic push;
  logic pop;
  logic full;

  always_comb begin
    fold = '0;
    for (int k = 0; k < NSRC; k++) begin
      fold = fold ^ i_sampled[k*SRC_WIDTH +: SRC_WIDTH];
    end
  end

  assign step = OUT_WIDTH'(crc_step(CRC_MAXW'(crc_q), CRC_MAXW'(POLY),
                                    OUT_WIDTH, DATA_MAXW'(fold), SRC_WIDTH));

  assign accept = i_sampled_valid && !fail_q && !i_clear_fail;
  assign cnt_nxt = cnt_q + 4'd1;
  assign done = accept && (cnt_nxt == 4'(SAMPLES_PER_OUT));

  assign rct_nxt = (last_vld && step == last_q)
                 ? ((rct_q == 8'hff) ? rct_q : rct_q + 8'd1)
                 : 8'd1;
  assign rct_trip = (rct_nxt >= 8'(RCT_CUTOFF));
  assign trip = done && (rct_trip || apt_trip);
  assign push = done && !trip;
  assign pop = i_read && o_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      crc_q    <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      last_vld <= 1'b0;
      rct_q    <= '0;
      fail_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      if (push && full && !pop && drop_q != 8'hff) drop_q <= drop_q + 8'd1;
      if (i_clear_fail) begin
        crc_q    <= '0;
        cnt_q    <= '0;
        last_vld <= 1'b0;
        rct_q    <= '0;
        fail_q   <= 1'b0;
      end else if (accept) begin
        if (done) begin
          crc_q    <= '0;
          cnt_q    <= '0;
          last_q   <= step;
          last_vld <= 1'b1;
          rct_q    <= rct_nxt;
          if (trip) fail_q <= 1'b1;
        end else begin
          crc_q <= step;
          cnt_q <= cnt_nxt;
        end
      end
    end
  end

`ifdef TRNG_APT_EN
  logic [6:0] win_q;
  logic [OUT_WIDTH-1:0] ref_q;
  logic [3:0] match_q;
  logic [3:0] match_nxt;

  assign match_nxt = match_q + 4'd1;
  assign apt_trip = (win_q != '0) && (step == ref_q) &&
                    (match_nxt >= 4'(APT_CUTOFF));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear_fail) begin
      win_q   <= '0;
      ref_q   <= '0;
      match_q <= '0;
    end else if (done) begin
      if (win_q == '0) begin
        ref_q   <= step;
        win_q   <= 7'd1;
        match_q <= '0;
      end else begin
        win_q <= (win_q == 7'(APT_WINDOW - 1)) ? '0 : win_q + 7'd1;
        if (step == ref_q) match_q <= match_nxt;
      end
    end
  end
`else
  assign apt_trip = 1'b0;
`endif

  trng_word_fifo #(
    .WIDTH(OUT_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(i_clk),
    .reset(i_reset),
    .push(push),
    .pop(pop),
    .flush(trip),
    .din(step),
    .dout(o_dat),
    .level(level),
    .full(full)
  );

  assign o_level = level;
  assign o_valid = (level != '0) && !fail_q;
  assign o_health_fail = fail_q;
  assign o_drop_cnt = drop_q;

endmodule
